// File: rtl/burst_ram_arbiter.sv
// Two-port round-robin arbiter in front of a burst RAM; moves whole cache lines.
// Latency: write 1 + (N-1) + wait-for-not-busy + 1 cycles; read 1 + RAM latency + N + 1.
// Backpressure: one transaction in flight; other requesters hold valid until their done pulse.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req0_*                       instruction-cache line reads (valid/addr in, done/rd_line out)
//   req1_*                       data-cache line reads/writes (valid/cmd/addr/wr_line in, done/rd_line out)
//   ram_cmd/_en/_addr/_wr_data   single-cycle burst command plus serialized write words
//   ram_rd_data/_valid           returned read words, possibly with gaps
//   ram_init_calib, ram_busy     RAM status; both gate new grants
module burst_ram_arbiter #(
  parameter int AddressBitWidth = 4,
  parameter int DataBitWidth    = 64,
  parameter int BurstDataCount  = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     req0_valid,
  input  logic [AddressBitWidth-1:0]               req0_addr,
  output logic                                     req0_done,
  output logic [DataBitWidth*BurstDataCount-1:0]   req0_rd_line,
  input  logic                                     req1_valid,
  input  logic                                     req1_cmd,
  input  logic [AddressBitWidth-1:0]               req1_addr,
  input  logic [DataBitWidth*BurstDataCount-1:0]   req1_wr_line,
  output logic                                     req1_done,
  output logic [DataBitWidth*BurstDataCount-1:0]   req1_rd_line,
  output logic                                     ram_cmd,
  output logic                                     ram_cmd_en,
  output logic [AddressBitWidth-1:0]               ram_addr,
  output logic [DataBitWidth-1:0]                  ram_wr_data,
  output logic [DataBitWidth/8-1:0]                ram_data_mask,
  input  logic [DataBitWidth-1:0]                  ram_rd_data,
  input  logic                                     ram_rd_data_valid,
  input  logic                                     ram_init_calib,
  input  logic                                     ram_busy
);

  localparam int CntW  = $clog2(BurstDataCount);
  localparam int LineW = DataBitWidth * BurstDataCount;
  localparam logic [CntW-1:0] LastCnt = CntW'(BurstDataCount - 1);
  // Clears the in-burst offset bits so every burst starts on a line boundary.
  localparam logic [AddressBitWidth-1:0] AlignMask = ~AddressBitWidth'(BurstDataCount - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WRITE, WAIT, READ, DONE} state_e;

  state_e                     state_q, state_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic                       grant_q, grant_d;
  logic                       last_grant_q, last_grant_d;
  logic                       wr_q, wr_d;
  logic [AddressBitWidth-1:0] addr_q, addr_d;
  logic [LineW-1:0]           wr_line_q, wr_line_d;
  logic [LineW-1:0]           line_q, line_d;
  logic [LineW-1:0]           rd_line0_q, rd_line0_d;
  logic [LineW-1:0]           rd_line1_q, rd_line1_d;
  logic                       pick;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;  // port 0 wins the first tie after reset
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wr_line_q    <= '0;
      line_q       <= '0;
      rd_line0_q   <= '0;
      rd_line1_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wr_line_q    <= wr_line_d;
      line_q       <= line_d;
      rd_line0_q   <= rd_line0_d;
      rd_line1_q   <= rd_line1_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wr_line_d    = wr_line_q;
    line_d       = line_q;
    rd_line0_d   = rd_line0_q;
    rd_line1_d   = rd_line1_q;
    // On a tie the port that did not go last wins; otherwise whoever is valid.
    pick = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

    unique case (state_q)
      IDLE: begin
        if (ram_init_calib && !ram_busy && (req0_valid || req1_valid)) begin
          grant_d = pick;
          wr_d    = pick & req1_cmd;  // port 0 only ever reads
          addr_d  = (pick ? req1_addr : req0_addr) & AlignMask;
          if (pick & req1_cmd) wr_line_d = req1_wr_line;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        last_grant_d = grant_q;
        if (wr_q) begin
          cnt_d   = CntW'(1);  // word 0 goes out with the command itself
          state_d = WRITE;
        end else begin
          state_d = READ;
        end
      end
      WRITE: begin
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (!ram_busy) state_d = DONE;
      end
      READ: begin
        if (ram_rd_data_valid) begin
          line_d[cnt_q*DataBitWidth +: DataBitWidth] = ram_rd_data;
          if (cnt_q == LastCnt) begin
            cnt_d   = '0;
            state_d = DONE;
            // Publish the completed line now so it is valid alongside done.
            if (grant_q) rd_line1_d = line_d;
            else         rd_line0_d = line_d;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    ram_cmd_en  = 1'b0;
    ram_cmd     = 1'b0;
    ram_addr    = '0;
    ram_wr_data = '0;
    req0_done   = 1'b0;
    req1_done   = 1'b0;
    unique case (state_q)
      ISSUE: begin
        ram_cmd_en = 1'b1;
        ram_cmd    = wr_q;
        ram_addr   = addr_q;
        if (wr_q) ram_wr_data = wr_line_q[DataBitWidth-1:0];
      end
      WRITE: ram_wr_data = wr_line_q[cnt_q*DataBitWidth +: DataBitWidth];
      DONE: begin
        req0_done = ~grant_q;
        req1_done = grant_q;
      end
      default: ;
    endcase
  end

  assign ram_data_mask = '0;
  assign req0_rd_line  = rd_line0_q;
  assign req1_rd_line  = rd_line1_q;

endmodule
